// File: rtl/cpu64_pipeline_ctrl.sv
// Hazard sequencer for the 5-stage cpu64 pipe: per-stage stall/bubble/squash strobes.
// Optional perf counters are built when CPU64_PIPE_PERF_EN is defined.
module cpu64_pipeline_ctrl #(
    parameter int TRAP_LAT = 2,
    parameter int CNT_W    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ex_valid_i,
    input  logic       mem_valid_i,
    input  logic       wb_valid_i,
    input  logic       if_busy_i,
    input  logic       ex_busy_i,
    input  logic       mem_busy_i,
    input  logic       load_use_i,
    input  logic       fence_i,
    input  logic       redirect_i,
    input  logic       trap_i,
    output logic       if_stall_o,
    output logic       id_stall_o,
    output logic       ex_stall_o,
    output logic       mem_stall_o,
    output logic       id_bubble_o,
    output logic       ex_bubble_o,
    output logic       mem_bubble_o,
    output logic       wb_bubble_o,
    output logic       if_squash_o,
    output logic       id_squash_o,
    output logic       ex_squash_o,
    output logic       mem_squash_o,
    output logic [1:0] state_o
`ifdef CPU64_PIPE_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
`endif
);

    typedef enum logic [1:0] {RUN = 2'd0, HOLD_SQ = 2'd1, DRAIN = 2'd2, TRAP_WAIT = 2'd3} state_t;
    typedef enum logic [1:0] {PK_NONE = 2'd0, PK_REDIR = 2'd1, PK_TRAP = 2'd2} pend_t;

    localparam logic [CNT_W-1:0] LAT = CNT_W'(TRAP_LAT);

    state_t           state_q, state_d;
    pend_t            pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lvl;        // number of stalled stages counted from IF; bubble goes just below
    logic             sq_front, sq_all, drain_done, trap_pend;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            pend_q  <= PK_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        sq_front   = 1'b0;
        sq_all     = 1'b0;
        drain_done = ~(ex_valid_i | mem_valid_i | wb_valid_i | mem_busy_i | ex_busy_i);
        trap_pend  = (pend_q == PK_TRAP) | trap_i;

        if (mem_busy_i)      lvl = 3'd4;
        else if (ex_busy_i)  lvl = 3'd3;
        else if (load_use_i) lvl = 3'd2;
        else if (if_busy_i)  lvl = 3'd1;
        else                 lvl = 3'd0;
        if (state_q == TRAP_WAIT && lvl < 3'd1) lvl = 3'd1;
        if (state_q == DRAIN && !drain_done && lvl < 3'd2) lvl = 3'd2;

        if (state_q == TRAP_WAIT && cnt_q != '0) cnt_d = cnt_q - 1'b1;

        if (state_q == HOLD_SQ) begin
            if (trap_i) pend_d = PK_TRAP;
            sq_all   = trap_pend;
            sq_front = ~trap_pend;
            if (!mem_busy_i && !ex_busy_i) begin
                state_d = trap_pend ? TRAP_WAIT : RUN;
                cnt_d   = trap_pend ? LAT : '0;
                pend_d  = PK_NONE;
            end
        end else if (trap_i) begin
            sq_all = 1'b1;
            if (mem_busy_i) begin
                state_d = HOLD_SQ;
                pend_d  = PK_TRAP;
            end else begin
                state_d = TRAP_WAIT;
                cnt_d   = LAT;
            end
        end else if (redirect_i && state_q != TRAP_WAIT) begin
            // a redirect in TRAP_WAIT is younger than the trap and is dropped
            sq_front = 1'b1;
            if (mem_busy_i || ex_busy_i) begin
                state_d = HOLD_SQ;
                pend_d  = PK_REDIR;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN:       if (fence_i) state_d = DRAIN;
                DRAIN:     if (drain_done) state_d = RUN;
                TRAP_WAIT: if (cnt_q <= 1) state_d = RUN;
                default:   state_d = state_q;
            endcase
        end
    end

    assign if_stall_o   = lvl > 3'd0;
    assign id_stall_o   = lvl > 3'd1;
    assign ex_stall_o   = lvl > 3'd2;
    assign mem_stall_o  = lvl > 3'd3;
    assign id_bubble_o  = lvl == 3'd1;
    assign ex_bubble_o  = lvl == 3'd2;
    assign mem_bubble_o = lvl == 3'd3;
    assign wb_bubble_o  = lvl == 3'd4;
    assign if_squash_o  = sq_front | sq_all;
    assign id_squash_o  = sq_front | sq_all;
    assign ex_squash_o  = sq_all;
    assign mem_squash_o = sq_all;
    assign state_o      = state_q;

`ifdef CPU64_PIPE_PERF_EN
    logic flush_acc;
    assign flush_acc = trap_i | (redirect_i & (state_q == RUN || state_q == DRAIN));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (if_stall_o && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 1'b1;
            if (flush_acc && flush_count_o != '1)   flush_count_o  <= flush_count_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu64_pipeline_ctrl.sv
// Directed bench for cpu64_pipeline_ctrl: literal per-step expectations plus a
// per-cycle comparison against an abstract mode/countdown model.
module tb_cpu64_pipeline_ctrl;
    localparam int TRAP_LAT = 2;

    localparam logic [10:0] TRAP = 11'd1,   REDIR = 11'd2,   FENCE = 11'd4,  LU  = 11'd8;
    localparam logic [10:0] MEMB = 11'd16,  EXB   = 11'd32,  IFB   = 11'd64, WBV = 11'd128;
    localparam logic [10:0] MEMV = 11'd256, EXV   = 11'd512, RST   = 11'd1024;

    logic clk = 1'b0;
    logic rst, exv, memv, wbv, ifb, exb, memb, lu, fence, redir, trap;
    logic if_st, id_st, ex_st, mem_st, id_b, ex_b, mem_b, wb_b, if_sq, id_sq, ex_sq, mem_sq;
    logic [1:0] state;
`ifdef CPU64_PIPE_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    cpu64_pipeline_ctrl #(.TRAP_LAT(TRAP_LAT), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(exv), .mem_valid_i(memv), .wb_valid_i(wbv),
        .if_busy_i(ifb), .ex_busy_i(exb), .mem_busy_i(memb), .load_use_i(lu),
        .fence_i(fence), .redirect_i(redir), .trap_i(trap),
        .if_stall_o(if_st), .id_stall_o(id_st), .ex_stall_o(ex_st), .mem_stall_o(mem_st),
        .id_bubble_o(id_b), .ex_bubble_o(ex_b), .mem_bubble_o(mem_b), .wb_bubble_o(wb_b),
        .if_squash_o(if_sq), .id_squash_o(id_sq), .ex_squash_o(ex_sq), .mem_squash_o(mem_sq),
        .state_o(state)
`ifdef CPU64_PIPE_PERF_EN
        , .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
`endif
    );

    // {state, stall IF..MEM, bubble ID..WB, squash IF..MEM}
    logic [13:0] dut_vec;
    assign dut_vec = {state, if_st, id_st, ex_st, mem_st, id_b, ex_b, mem_b, wb_b,
                      if_sq, id_sq, ex_sq, mem_sq};

    // Model: mode 0 run, 1 holding squash, 2 draining, 3 trap countdown.
    int m_mode = 0, m_left = 0, m_kind = 0;   // kind 1 redirect, 2 trap
    longint m_stalls = 0, m_flush = 0;

    function automatic logic [13:0] model_out();
        int depth, nsq;
        bit empty;
        empty = !(exv || memv || wbv || memb || exb);
        depth = memb ? 4 : exb ? 3 : lu ? 2 : ifb ? 1 : 0;
        if (m_mode == 3 && depth < 1) depth = 1;
        if (m_mode == 2 && !empty && depth < 2) depth = 2;
        nsq = 0;
        if (m_mode == 1)                     nsq = (m_kind == 2 || trap) ? 4 : 2;
        else if (trap)                       nsq = 4;
        else if (redir && m_mode != 3)       nsq = 2;
        model_out = '0;
        model_out[13:12] = 2'(m_mode);
        for (int s = 0; s < 4; s++) begin
            model_out[11 - s] = depth > s;              // stalls IF..MEM
            model_out[7 - s]  = depth == s + 1;         // bubbles ID..WB
            model_out[3 - s]  = nsq > s;                // squashes IF..MEM
        end
    endfunction

    task automatic model_step();
        bit empty;
        empty = !(exv || memv || wbv || memb || exb);
        if (rst) begin
            m_mode = 0; m_left = 0; m_kind = 0; m_stalls = 0; m_flush = 0;
            return;
        end
        if (model_out() & 14'b00_1000_0000_0000) m_stalls++;
        if (trap || (redir && (m_mode == 0 || m_mode == 2))) m_flush++;
        if (m_mode == 1) begin
            if (trap) m_kind = 2;
            if (!memb && !exb) begin
                m_mode = (m_kind == 2) ? 3 : 0; m_left = TRAP_LAT; m_kind = 0;
            end
        end else if (trap) begin
            if (memb) begin m_mode = 1; m_kind = 2; end
            else begin m_mode = 3; m_left = TRAP_LAT; end
        end else if (redir && m_mode != 3) begin
            if (memb || exb) begin m_mode = 1; m_kind = 1; end
            else m_mode = 0;
        end else if (m_mode == 0 && fence) m_mode = 2;
        else if (m_mode == 2 && empty)     m_mode = 0;
        else if (m_mode == 3) begin
            if (m_left <= 1) m_mode = 0;
            else m_left--;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (dut_vec !== model_out()) begin
                bad++;
                $display("FAIL model t=%0t got=%b want=%b", $time, dut_vec, model_out());
            end
`ifdef CPU64_PIPE_PERF_EN
            total++;
            if (stall_cycles !== 32'(m_stalls) || flush_count !== 16'(m_flush)) begin
                bad++;
                $display("FAIL perf got=%0d/%0d want=%0d/%0d", stall_cycles, flush_count,
                         m_stalls, m_flush);
            end
`endif
        end
        model_step();
    end

    task automatic drive(input logic [10:0] v);
        {rst, exv, memv, wbv, ifb, exb, memb, lu, fence, redir, trap} = v;
    endtask

    // apply inputs for one cycle and check the combinational outputs mid-cycle
    task automatic step(input logic [10:0] v, input logic [13:0] exp, input string nm);
        drive(v);
        @(negedge clk);
        #1;
        total++;
        if (dut_vec !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, dut_vec, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(RST);
        @(posedge clk); #1;
        chk_on = 1'b1;
        step(RST, 14'b00_0000_0000_0000, "reset");
        step(0,   14'b00_0000_0000_0000, "idle");

        step(LU,  14'b00_1100_0100_0000, "load_use");
        step(0,   14'b00_0000_0000_0000, "load_use_rel");
        step(IFB, 14'b00_1000_1000_0000, "if_busy");
        step(EXB, 14'b00_1110_0010_0000, "ex_busy");
        step(MEMB|LU|IFB, 14'b00_1111_0001_0000, "mem_busy_wins");

        step(REDIR|MEMB, 14'b00_1111_0001_1100, "redir_busy0");
        step(MEMB,       14'b01_1111_0001_1100, "redir_busy1");
        step(MEMB,       14'b01_1111_0001_1100, "redir_busy2");
        step(0,          14'b01_0000_0000_1100, "redir_final");
        step(0,          14'b00_0000_0000_0000, "redir_done");

        step(TRAP, 14'b00_0000_0000_1111, "trap");
        step(0,    14'b11_1000_1000_0000, "trap_wait1");
        step(0,    14'b11_1000_1000_0000, "trap_wait2");
        step(0,    14'b00_0000_0000_0000, "trap_done");

        step(FENCE|EXV|MEMV|WBV, 14'b00_0000_0000_0000, "fence");
        step(EXV|MEMV|WBV,       14'b10_1100_0100_0000, "drain1");
        step(MEMV|WBV,           14'b10_1100_0100_0000, "drain2");
        step(WBV,                14'b10_1100_0100_0000, "drain3");
        step(0,                  14'b10_0000_0000_0000, "drain_rel");
        step(0,                  14'b00_0000_0000_0000, "drain_done");

        step(FENCE, 14'b00_0000_0000_0000, "fence_empty");
        step(0,     14'b10_0000_0000_0000, "drain_empty");
        step(0,     14'b00_0000_0000_0000, "drain_empty_done");

        step(REDIR|TRAP, 14'b00_0000_0000_1111, "redir_trap");
        step(RST,        14'b11_1000_1000_0000, "rst_in_wait");
        step(0,          14'b00_0000_0000_0000, "after_rst");

        step(TRAP|MEMB, 14'b00_1111_0001_1111, "trap_busy");
        step(0,         14'b01_0000_0000_1111, "trap_hold_final");
        step(0,         14'b11_1000_1000_0000, "trap_hold_wait1");
        step(0,         14'b11_1000_1000_0000, "trap_hold_wait2");
        step(0,         14'b00_0000_0000_0000, "trap_hold_done");

        step(TRAP,  14'b00_0000_0000_1111, "trap_b");
        step(MEMB,  14'b11_1111_0001_0000, "wait_mem_busy");
        step(REDIR, 14'b11_1000_1000_0000, "wait_redir_ign");
        step(0,     14'b00_0000_0000_0000, "wait_b_done");

        step(TRAP, 14'b00_0000_0000_1111, "trap_c");
        step(TRAP, 14'b11_1000_1000_1111, "trap_reload");
        step(0,    14'b11_1000_1000_0000, "reload_w1");
        step(0,    14'b11_1000_1000_0000, "reload_w2");
        step(0,    14'b00_0000_0000_0000, "reload_done");

        step(FENCE,     14'b00_0000_0000_0000, "fence_d");
        step(EXV|REDIR, 14'b10_1100_0100_1100, "drain_redir");
        step(0,         14'b00_0000_0000_0000, "drain_redir_done");

        step(REDIR|EXB, 14'b00_1110_0010_1100, "redir_exb");
        step(EXB|TRAP,  14'b01_1110_0010_1111, "hold_upgrade");
        step(0,         14'b01_0000_0000_1111, "upgrade_final");
        step(0,         14'b11_1000_1000_0000, "upgrade_w1");
        step(0,         14'b11_1000_1000_0000, "upgrade_w2");
        step(0,         14'b00_0000_0000_0000, "upgrade_done");

        drive(RST);
        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
